simple_fsm: RTL and testbench

SIMPLE_FSM -- requirements
Module: simple_fsm

---
 rtl/simple_fsm.sv | 143 ++++++++++++++
 tb/tb_simple_fsm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_fsm.sv
// simple_fsm: small loop buffer. A short backward branch seen while idle arms a
// capture of the loop body (target .. branch). Once the closing branch is
// captured, the buffer replays the body and stalls upstream fetch. A mispredict
// during replay ends the loop and redirects fetch to the instruction after the
// branch.
//
// Output qualification: flush is a one-cycle valid strobe for new_pc. new_pc
// is meaningful only while flush=1 and reads 0 otherwise. No ready is involved,
// because the consumer must act on the flush in the same cycle.
module simple_fsm #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] curr_PC,
  input  logic [31:0] instruction,
  input  logic [31:0] immediate,
  input  logic        mispredict,
  output logic        block_signal,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] out_instruction,
  output logic [1:0]  dbg_state_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    REPLAY = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            flush_q, flush_d;
  logic [31:0]     new_pc_q, new_pc_d;
  logic [31:0]     tgt_q, tgt_d;
  logic [IW-1:0]   last_q, last_d;   // len-1: index of the closing branch
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ridx_q, ridx_d;
  logic            wr_en;

  logic [31:0]     instr_buf [DEPTH];
  logic [31:0]     pc_buf    [DEPTH];

  logic [31:0]     neg_imm;
  logic [31:0]     rec_pc;
  logic            is_bwd;

  // A branch qualifies only if its offset fits the buffer (len <= DEPTH).
  assign neg_imm = 32'd0 - immediate;
  assign is_bwd  = (instruction[6:0] == 7'b1100011) && immediate[31] &&
                   (neg_imm >= 32'd1) && (neg_imm <= 32'(DEPTH - 1));
  // PC expected for the entry being captured: tgt + 4*idx.
  assign rec_pc  = tgt_q + {{(30-IW){1'b0}}, idx_q, 2'b00};

  // Next-state logic. Mispredict outranks branch detection and capture.
  always_comb begin
    state_d  = state_q;
    flush_d  = 1'b0;
    new_pc_d = 32'd0;
    tgt_d    = tgt_q;
    last_d   = last_q;
    idx_d    = idx_q;
    ridx_d   = ridx_q;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mispredict && is_bwd) begin
          state_d = RECORD;
          tgt_d   = curr_PC + {immediate[29:0], 2'b00};
          last_d  = neg_imm[IW-1:0];
          idx_d   = '0;
        end
      end
      RECORD: begin
        if (mispredict || (curr_PC != rec_pc)) begin
          state_d = IDLE;
        end else if (idx_q == last_q) begin
          // PC matched at the last index, so this is the branch PC itself.
          if (is_bwd) begin
            wr_en   = 1'b1;
            state_d = REPLAY;
            ridx_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          wr_en = 1'b1;
          idx_d = idx_q + 1'b1;
        end
      end
      REPLAY: begin
        if (mispredict) begin
          state_d  = IDLE;
          flush_d  = 1'b1;
          // The last entry holds the branch PC, so the buffer supplies the
          // fall-through address.
          new_pc_d = pc_buf[last_q] + 32'd4;
        end else begin
          ridx_d = (ridx_q == last_q) ? '0 : ridx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers, cleared asynchronously so reset abandons any loop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      flush_q  <= 1'b0;
      new_pc_q <= 32'd0;
      tgt_q    <= 32'd0;
      last_q   <= '0;
      idx_q    <= '0;
      ridx_q   <= '0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
      tgt_q    <= tgt_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      ridx_q   <= ridx_d;
    end
  end

  // Loop storage. Each entry holds {instruction, PC}, and the contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_buf[idx_q] <= instruction;
      pc_buf[idx_q]    <= curr_PC;
    end
  end

  assign block_signal    = (state_q == REPLAY);
  assign out_instruction = block_signal ? instr_buf[ridx_q] : instruction;
  assign flush           = flush_q;
  assign new_pc          = new_pc_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_simple_fsm.sv
// tb_simple_fsm: directed loop scenarios plus randomized loops. The bench checks
// them against a queue-based loop model through an expected-output scoreboard.
module tb_simple_fsm;

  localparam int DEPTH = 8;
  localparam logic [31:0] BR = 32'hFC000AE3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] curr_PC = 32'd0;
  logic [31:0] instruction = 32'd0;
  logic [31:0] immediate = 32'd0;
  logic        mispredict = 1'b0;
  logic        block_signal, flush;
  logic [31:0] new_pc, out_instruction;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  simple_fsm #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .curr_PC(curr_PC), .instruction(instruction),
    .immediate(immediate), .mispredict(mispredict), .block_signal(block_signal),
    .flush(flush), .new_pc(new_pc), .out_instruction(out_instruction),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [65:0] exp_q[$];   // {block_signal, flush, new_pc, out_instruction}
  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Loop is held as a list of captured instructions. Capture expects PCs
  // target, target+4, ..., and closes when the branch PC itself matches.
  logic [31:0] loop_q[$];
  bit          capturing = 0;
  bit          looping = 0;
  bit          m_flush = 0;
  logic [31:0] m_flush_pc = 32'd0;
  logic [31:0] m_br = 32'd0;
  logic [31:0] m_tgt = 32'd0;
  int          m_pos = 0;

  function automatic bit is_back(input logic [31:0] ins, input logic [31:0] imm);
    return (ins[6:0] == 7'b1100011) && ($signed(imm) < 0) &&
           ($signed(imm) >= -(DEPTH - 1));
  endfunction

  function automatic logic [65:0] model_out(input logic [31:0] ins);
    logic [31:0] o;
    o = looping ? loop_q[m_pos] : ins;
    return {looping, m_flush, (m_flush ? m_flush_pc : 32'd0), o};
  endfunction

  function automatic void model_step(input logic [31:0] pc, input logic [31:0] ins,
                                     input logic [31:0] imm, input logic mp);
    m_flush = 0;
    if (looping) begin
      if (mp) begin
        looping    = 0;
        m_flush    = 1;
        m_flush_pc = m_br + 32'd4;
      end else begin
        m_pos = (m_pos + 1) % loop_q.size();
      end
    end else if (capturing) begin
      if (mp || (pc != m_tgt + 32'(4 * loop_q.size()))) begin
        capturing = 0;
      end else if (pc == m_br) begin
        capturing = 0;
        if (is_back(ins, imm)) begin
          loop_q.push_back(ins);
          looping = 1;
          m_pos   = 0;
        end
      end else begin
        loop_q.push_back(ins);
      end
    end else if (!mp && is_back(ins, imm)) begin
      capturing = 1;
      loop_q.delete();
      m_br  = pc;
      m_tgt = pc + 32'($signed(imm) * 4);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] imm, input logic mp);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    curr_PC     = pc;
    instruction = ins;
    immediate   = imm;
    mispredict  = mp;
    exp_q.push_back(model_out(ins));
    model_step(pc, ins, imm, mp);
  endtask

  task automatic do_reset();
    logic [31:0] ins;
    @(posedge clk);
    #1;
    ins         = $urandom();
    reset       = 1'b0;
    instruction = ins;
    mispredict  = 1'b0;
    #1;
    // Reset is asynchronous, so the outputs must already be cleared here.
    n_vec++;
    if (block_signal !== 1'b0 || flush !== 1'b0 || new_pc !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset: block=%0b flush=%0b new_pc=%h, required 0/0/0",
               block_signal, flush, new_pc);
    end
    looping   = 0;
    capturing = 0;
    m_flush   = 0;
    exp_q.push_back({1'b0, 1'b0, 32'd0, ins});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply($urandom(), 32'h13, $urandom(), 1'b0);
  endtask

  // Capture loop body: PCs base..base+4*(n-1), the last slot being the branch.
  task automatic capture(input logic [31:0] br_pc, input int len);
    logic [31:0] imm;
    imm = 32'(-(len - 1));
    apply(br_pc, BR, imm, 1'b0);
    for (int i = 0; i < len - 1; i++)
      apply(br_pc + 32'(4 * (i - len + 1)), 32'h13 + 32'(i), 32'd0, 1'b0);
    apply(br_pc, BR, imm, 1'b0);
  endtask

  task automatic replay(input int n, input bit exit_mp);
    for (int i = 0; i < n; i++) apply($urandom(), 32'hzzzzzzzz, $urandom(), 1'b0);
    if (exit_mp) apply($urandom(), 32'hzzzzzzzz, $urandom(), 1'b1);
  endtask

  task automatic rand_loop();
    int len;
    logic [31:0] base, br_pc, imm, pc, ins, r;
    len   = $urandom_range(2, DEPTH + 1);
    base  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    br_pc = base + 32'(4 * (len - 1));
    imm   = 32'(-(len - 1));
    r     = $urandom();
    apply(br_pc, {r[31:7], 7'b1100011}, imm, 1'b0);
    for (int i = 0; i < len; i++) begin
      pc  = base + 32'(4 * i);
      if ($urandom_range(0, 15) == 0) pc = pc ^ 32'h40;
      r   = $urandom();
      ins = (i == len - 1) ? {r[31:7], 7'b1100011} : r;
      apply(pc, ins, (i == len - 1) ? imm : $urandom(), ($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < $urandom_range(1, 3 * len); i++)
      apply($urandom(), $urandom(), $urandom(), 1'b0);
    if ($urandom_range(0, 7) == 0) do_reset();
    apply($urandom(), $urandom(), $urandom(), 1'b1);
    idle_cycles($urandom_range(1, 3));
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [65:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {block_signal, flush, new_pc, out_instruction};
        n_vec++;
        if (act_v !== exp_v) begin
          n_err++;
          $display("FAIL cycle_out @%0t: block=%0b flush=%0b new_pc=%h out=%h, required block=%0b flush=%0b new_pc=%h out=%h",
                   $time, act_v[65], act_v[64], act_v[63:32], act_v[31:0],
                   exp_v[65], exp_v[64], exp_v[63:32], exp_v[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    do_reset();
    idle_cycles(2);

    // Canonical loop: capture, replay twice around, then exit.
    capture(32'h10C, 4);
    replay(9, 1'b1);
    idle_cycles(2);

    // Abort: second body PC is wrong.
    apply(32'h10C, BR, 32'(-3), 1'b0);
    apply(32'h100, 32'h13, 32'd0, 1'b0);
    apply(32'h200, 32'h14, 32'd0, 1'b0);
    idle_cycles(3);

    // Out of range offsets, then pass-through.
    apply(32'h40, BR, 32'(-8), 1'b0);
    apply(32'h44, 32'h55, 32'd0, 1'b0);
    apply(32'h48, BR, 32'd3, 1'b0);
    apply(32'h4C, 32'h66, 32'd0, 1'b0);

    // Longest loop that fits, plus mispredict while recording.
    capture(32'h81C, DEPTH);
    replay(DEPTH + 2, 1'b1);
    apply(32'h30, BR, 32'(-2), 1'b0);
    apply(32'h28, 32'h1, 32'd0, 1'b1);
    idle_cycles(2);

    // PC wraps through zero.
    capture(32'h4, 4);
    replay(5, 1'b1);
    idle_cycles(1);

    // Reset mid-replay, then a fresh loop must capture again.
    capture(32'h10C, 4);
    replay(5, 1'b0);
    do_reset();
    capture(32'h10C, 4);
    replay(3, 1'b1);
    idle_cycles(2);

    for (int i = 0; i < 60; i++) rand_loop();

    @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected outputs left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
